data_req_initiator: RTL and testbench

DATA_REQ_INITIATOR -- requirements
Module: data_req_initiator

---
 rtl/data_req_initiator.sv | 240 ++++++++++++++++++++++++
 tb/tb_data_req_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_req_initiator.sv
// Turns accepted commands into req/gnt memory transactions and returns the responses in order.
// Latency: data_req_o one cycle after command accept; resp_valid_o one cycle after the credited rvalid.
// Backpressure: cmd_ready_o drops while a request is ungranted or MAX_OUTSTANDING commands await a response pop.

// Generic in-order FIFO. Head is read combinationally; pointers wrap at DEPTH.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push into a full FIFO without a pop.
module drq_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && (count == FULL_CNT) && !do_pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_vld && empty));
endmodule

module data_req_initiator #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    input  logic                    data_err_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    resp_we_o,
    output logic                    busy_o,
    output logic                    unexpected_rvalid_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  we;
    } resp_t;

    state_t           state_q;
    state_t           state_d;
    req_t             req_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] granted_q;
    logic             unexp_q;

    logic  cmd_acc;
    logic  gnt_acc;
    logic  rsp_credit;
    logic  rsp_pop;
    logic  we_head;
    logic  we_empty;
    logic  rsp_empty;
    resp_t rsp_push;
    resp_t rsp_head;

    // Gating with rst_n keeps cmd_ready_o low throughout reset even though the terms would allow it.
    assign cmd_ready_o = rst_n && (!data_req_o || data_gnt_i) && (inflight_q < MAX_CNT);
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;
    assign gnt_acc     = (state_q == REQ) && data_gnt_i;
    // granted_q is registered, so an rvalid in the same cycle as its own grant is not credited.
    assign rsp_credit  = data_rvalid_i && (granted_q != '0);
    assign rsp_pop     = resp_valid_o && resp_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In REQ a new accept implies a grant this cycle, so the next request follows back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_acc) state_d = REQ;
            REQ:  if (data_gnt_i && !cmd_acc) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (cmd_acc) begin
            req_q <= '{we: cmd_we_i, be: cmd_be_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            granted_q  <= '0;
            unexp_q    <= 1'b0;
        end else begin
            case ({cmd_acc, rsp_pop})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
            case ({gnt_acc, rsp_credit})
                2'b10:   granted_q <= granted_q + 1'b1;
                2'b01:   granted_q <= granted_q - 1'b1;
                default: granted_q <= granted_q;
            endcase
            if (data_rvalid_i && (granted_q == '0)) begin
                unexp_q <= 1'b1;
            end
        end
    end

    // Remembers whether each granted transaction was a write, in grant order.
    drq_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_we_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (gnt_acc),
        .push_dat (req_q.we),
        .pop_vld  (rsp_credit),
        .head_dat (we_head),
        .empty    (we_empty)
    );

    assign rsp_push = '{rdata: (we_head ? '0 : data_rdata_i), err: data_err_i, we: we_head};

    drq_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rsp_credit),
        .push_dat (rsp_push),
        .pop_vld  (rsp_pop),
        .head_dat (rsp_head),
        .empty    (rsp_empty)
    );

    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = req_q.we;
    assign data_be_o    = req_q.be;
    assign data_addr_o  = req_q.addr;
    assign data_wdata_o = req_q.wdata;

    // Head fields are masked while empty so uninitialised storage never reaches the outputs.
    assign resp_valid_o = !rsp_empty;
    assign resp_rdata_o = rsp_empty ? '0 : rsp_head.rdata;
    assign resp_err_o   = !rsp_empty && rsp_head.err;
    assign resp_we_o    = !rsp_empty && rsp_head.we;

    assign busy_o              = (inflight_q != '0);
    assign unexpected_rvalid_o = unexp_q;

    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q <= MAX_CNT);
    a_credit_track: assert property (@(posedge clk) disable iff (!rst_n)
        (granted_q == '0) == we_empty);
endmodule

// File: tb/tb_data_req_initiator.sv
// Scoreboard bench for data_req_initiator: inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge or 1 unit after the rising edge.
module tb_data_req_initiator;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid_i, cmd_we_i;
    logic [3:0]  cmd_be_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic        cmd_ready_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o, resp_we_o;
    logic [31:0] resp_rdata_o;
    logic        busy_o, unexpected_rvalid_o;

    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    logic [31:0] gaddr_q[$];
    logic [31:0] mem_q[$];
    logic        last_acc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_req_initiator #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_we_i            (cmd_we_i),
        .cmd_be_i            (cmd_be_i),
        .cmd_addr_i          (cmd_addr_i),
        .cmd_wdata_i         (cmd_wdata_i),
        .data_req_o          (data_req_o),
        .data_we_o           (data_we_o),
        .data_be_o           (data_be_o),
        .data_addr_o         (data_addr_o),
        .data_wdata_o        (data_wdata_o),
        .data_gnt_i          (data_gnt_i),
        .data_rvalid_i       (data_rvalid_i),
        .data_rdata_i        (data_rdata_i),
        .data_err_i          (data_err_i),
        .resp_valid_o        (resp_valid_o),
        .resp_ready_i        (resp_ready_i),
        .resp_rdata_o        (resp_rdata_o),
        .resp_err_o          (resp_err_o),
        .resp_we_o           (resp_we_o),
        .busy_o              (busy_o),
        .unexpected_rvalid_o (unexpected_rvalid_o)
    );

    // Advance one cycle: record handshakes on the falling edge, return 1 unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        last_acc = cmd_valid_i && cmd_ready_o;
        if (resp_valid_o && resp_ready_i) obs_q.push_back({resp_rdata_o, resp_err_o, resp_we_o});
        if (data_req_o && data_gnt_i) begin
            gaddr_q.push_back(data_addr_o);
            mem_q.push_back(data_addr_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_be_i = 4'h0; cmd_addr_i = '0; cmd_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        resp_ready_i = 1'b0;
    endtask

    task automatic clear_queues();
        exp_q.delete(); obs_q.delete(); gaddr_q.delete(); mem_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        cmd_valid_i = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", data_req_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready_o); end
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (unexpected_rvalid_o !== 1'b0) begin failures++; $display("FAIL rst_unexp got=%b exp=0", unexpected_rvalid_o); end
        checks++; if ({data_we_o, data_be_o, data_addr_o, data_wdata_o} !== 69'd0) begin failures++; $display("FAIL rst_data_fields got=%h exp=0", {data_we_o, data_be_o, data_addr_o, data_wdata_o}); end
        checks++; if ({resp_rdata_o, resp_err_o, resp_we_o} !== 34'd0) begin failures++; $display("FAIL rst_resp_fields got=%h exp=0", {resp_rdata_o, resp_err_o, resp_we_o}); end
        cmd_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready_o); end
        step();
    endtask

    task automatic test_single_read();
        clear_queues(); idle_inputs();
        cmd_valid_i = 1'b1; cmd_be_i = 4'hF; cmd_addr_i = 32'h100;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", cmd_ready_o); end
        step();
        cmd_valid_i = 1'b0; cmd_addr_i = 32'hFFFF_FFFF;
        checks++; if ({data_req_o, data_addr_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL single_req1 got=%b/%h exp=1/100", data_req_o, data_addr_o); end
        step();
        data_gnt_i = 1'b1;
        checks++; if (data_req_o !== 1'b1) begin failures++; $display("FAIL single_req2 got=%b exp=1", data_req_o); end
        step();
        data_gnt_i = 1'b0;
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL single_req_end got=%b exp=0", data_req_o); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        exp_q.push_back({32'hDEAD_BEEF, 1'b0, 1'b0});
        step();
        data_rvalid_i = 1'b0; data_rdata_i = '0;
        checks++; if ({resp_valid_o, busy_o} !== 2'b11) begin failures++; $display("FAIL single_resp_busy got=%b exp=11", {resp_valid_o, busy_o}); end
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        checks++; if ({resp_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL single_after_pop got=%b exp=00", {resp_valid_o, busy_o}); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL single_resp got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues(); idle_inputs();
        data_gnt_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_be_i = 4'hF; cmd_addr_i = 32'h200; cmd_wdata_i = 32'hA0A0_A0A0;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", cmd_ready_o); end
        step();
        cmd_addr_i = 32'h204; cmd_wdata_i = 32'hB0B0_B0B0;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", cmd_ready_o); end
        checks++; if ({data_req_o, data_addr_o} !== {1'b1, 32'h200}) begin failures++; $display("FAIL b2b_req1 got=%b/%h exp=1/200", data_req_o, data_addr_o); end
        step();
        cmd_valid_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
        exp_q.push_back({32'h0, 1'b0, 1'b1});
        #1;
        checks++; if ({data_req_o, data_addr_o} !== {1'b1, 32'h204}) begin failures++; $display("FAIL b2b_req2 got=%b/%h exp=1/204", data_req_o, data_addr_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", cmd_ready_o); end
        step();
        data_rdata_i = 32'h2222_2222;
        exp_q.push_back({32'h0, 1'b0, 1'b1});
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL b2b_req_end got=%b exp=0", data_req_o); end
        step();
        data_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_hold_ready%0d got=%b exp=0", i, cmd_ready_o); end
            step();
        end
        resp_ready_i = 1'b1;
        #1;
        checks++; if ({resp_valid_o, cmd_ready_o} !== 2'b10) begin failures++; $display("FAIL b2b_no_bypass got=%b exp=10", {resp_valid_o, cmd_ready_o}); end
        step();
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop got=%b exp=1", cmd_ready_o); end
        step();
        resp_ready_i = 1'b0; data_gnt_i = 1'b0;
        checks++; if (gaddr_q.size() != 2) begin failures++; $display("FAIL b2b_grant_count got=%0d exp=2", gaddr_q.size()); end
        else begin
            checks++; if ({gaddr_q[0], gaddr_q[1]} !== {32'h200, 32'h204}) begin failures++; $display("FAIL b2b_addr_order got=%h/%h exp=200/204", gaddr_q[0], gaddr_q[1]); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_resp got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_stall_hold();
        logic [69:0] snap;
        clear_queues(); idle_inputs();
        cmd_valid_i = 1'b1; cmd_be_i = 4'h5; cmd_addr_i = 32'h300; cmd_wdata_i = 32'h5A5A_5A5A;
        step();
        snap = {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o};
        checks++; if (snap !== {1'b1, 1'b0, 4'h5, 32'h300, 32'h5A5A_5A5A}) begin failures++; $display("FAIL stall_first got=%h", snap); end
        cmd_we_i = 1'b1; cmd_be_i = 4'hF; cmd_addr_i = 32'h3FC; cmd_wdata_i = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%b exp=0", i, cmd_ready_o); end
            checks++; if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !== snap) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}, snap); end
            step();
        end
        cmd_valid_i = 1'b0; data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", data_req_o); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        exp_q.push_back({32'hCAFE_F00D, 1'b0, 1'b0});
        step();
        data_rvalid_i = 1'b0; resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL stall_resp got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_error();
        clear_queues(); idle_inputs();
        data_gnt_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_be_i = 4'hF; cmd_addr_i = 32'h400;
        step();
        cmd_addr_i = 32'h404;
        step();
        cmd_valid_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0; data_err_i = 1'b1;
        exp_q.push_back({32'hBAD0_BAD0, 1'b1, 1'b0});
        step();
        data_gnt_i = 1'b0;
        data_rdata_i = 32'h600D_600D; data_err_i = 1'b0;
        exp_q.push_back({32'h600D_600D, 1'b0, 1'b0});
        step();
        data_rvalid_i = 1'b0;
        checks++; if (unexpected_rvalid_o !== 1'b0) begin failures++; $display("FAIL err_unexp_before got=%b exp=0", unexpected_rvalid_o); end
        step();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_F00D; data_err_i = 1'b1;
        step();
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        checks++; if (unexpected_rvalid_o !== 1'b1) begin failures++; $display("FAIL err_unexp_set got=%b exp=1", unexpected_rvalid_o); end
        resp_ready_i = 1'b1;
        repeat (3) step();
        resp_ready_i = 1'b0;
        checks++; if ({resp_valid_o, unexpected_rvalid_o} !== 2'b01) begin failures++; $display("FAIL err_drained_sticky got=%b exp=01", {resp_valid_o, unexpected_rvalid_o}); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL err_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL err_resp got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        clear_queues(); idle_inputs();
        cmd_valid_i = 1'b1; cmd_be_i = 4'hF; cmd_addr_i = 32'h500;
        step();
        cmd_addr_i = 32'h504; data_gnt_i = 1'b1;
        step();
        cmd_valid_i = 1'b0; data_gnt_i = 1'b0;
        checks++; if ({data_req_o, busy_o, cmd_ready_o} !== 3'b110) begin failures++; $display("FAIL midrst_before got=%b exp=110", {data_req_o, busy_o, cmd_ready_o}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({data_req_o, busy_o, cmd_ready_o} !== 3'b000) begin failures++; $display("FAIL midrst_immediate got=%b exp=000", {data_req_o, busy_o, cmd_ready_o}); end
        checks++; if ({data_addr_o, unexpected_rvalid_o} !== 33'd0) begin failures++; $display("FAIL midrst_fields got=%h exp=0", {data_addr_o, unexpected_rvalid_o}); end
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        checks++; if ({busy_o, resp_valid_o, unexpected_rvalid_o, cmd_ready_o} !== 4'b0001) begin failures++; $display("FAIL midrst_after got=%b exp=0001", {busy_o, resp_valid_o, unexpected_rvalid_o, cmd_ready_o}); end
        step();
        checks++; if ({data_req_o, busy_o} !== 2'b00) begin failures++; $display("FAIL midrst_settled got=%b exp=00", {data_req_o, busy_o}); end
    endtask

    task automatic test_wrap();
        int issued;
        clear_queues(); idle_inputs();
        issued = 0;
        last_acc = 1'b0;
        for (int cyc = 0; cyc < 3000 && obs_q.size() < 10; cyc++) begin
            if (last_acc) issued++;
            if (issued >= 10) cmd_valid_i = 1'b0;
            else if (!cmd_valid_i || last_acc) cmd_valid_i = ($urandom_range(0, 2) != 0);
            cmd_we_i = 1'b0; cmd_be_i = 4'hF;
            cmd_addr_i = 32'h1000 + 32'(issued) * 32'd4;
            data_gnt_i = 1'($urandom_range(0, 1));
            if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                void'(mem_q.pop_front());
                data_rvalid_i = 1'b1;
                data_rdata_i = $urandom;
                data_err_i = 1'($urandom_range(0, 1));
                exp_q.push_back({data_rdata_i, data_err_i, 1'b0});
            end else begin
                data_rvalid_i = 1'b0;
                data_rdata_i = $urandom;
                data_err_i = 1'b0;
            end
            resp_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        checks++; if (obs_q.size() != 10) begin failures++; $display("FAIL wrap_resp_count got=%0d exp=10", obs_q.size()); end
        checks++; if (gaddr_q.size() != 10) begin failures++; $display("FAIL wrap_grant_count got=%0d exp=10", gaddr_q.size()); end
        for (int k = 0; k < gaddr_q.size(); k++) begin
            checks++; if (gaddr_q[k] !== 32'h1000 + 32'(k) * 32'd4) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, gaddr_q[k], 32'h1000 + 32'(k) * 32'd4); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wrap_resp got=%h exp=%h", o, e); end
        end
        checks++; if ({busy_o, resp_valid_o} !== 2'b00) begin failures++; $display("FAIL wrap_idle got=%b exp=00", {busy_o, resp_valid_o}); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall_hold();
        test_error();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
